// File: rtl/dfs_pkg.sv
// dfs_pkg: shared state, source and counter definitions for the clock-select controller
package dfs_pkg;
  localparam int CNT_W = 8;
  localparam logic SRC1 = 1'b0;
  localparam logic SRC2 = 1'b1;
  typedef enum logic [1:0] {IDLE, SWITCH, DWELL} state_t;
endpackage

// File: rtl/dfs_timer.sv
// dfs_timer: loadable down-counter that stops at zero and flags it
module dfs_timer
  import dfs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] ld_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= ld_val;
    else if (!zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/dfs_sel_ctrl.sv
// dfs_sel_ctrl: two-requester arbiter and settle/dwell FSM driving a glitch-free clock select
module dfs_sel_ctrl
  import dfs_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DWELL_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_src,
  output logic [1:0] req_ready,
  output logic       sel,
  output logic       cur_src,
  output logic       busy,
  output logic       done
);
  localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWL_LD = CNT_W'(DWELL_CYCLES == 0 ? 0 : DWELL_CYCLES - 1);
  state_t state;
  logic acc_src, acc_sw, zero, load;
  logic [CNT_W-1:0] ld_val;
  // Requester 1 may only land a no-op while dwelling; a real switch there is emergency-only.
  always_comb begin
    req_ready[0] = !rst && req_valid[0] && state != SWITCH;
    req_ready[1] = !rst && req_valid[1] && !req_ready[0] &&
                   (state == IDLE || (state == DWELL && req_src[1] == sel));
    acc_src = req_ready[0] ? req_src[0] : req_src[1];
    acc_sw  = |req_ready && acc_src != sel;
    load    = acc_sw || (state != IDLE && zero);
    ld_val  = acc_sw ? SET_LD : (state == SWITCH && DWELL_CYCLES != 0) ? DWL_LD : '0;
  end
  assign busy = state == SWITCH;
  dfs_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .ld_val (ld_val),
    .zero   (zero)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      sel     <= SRC1;
      cur_src <= SRC1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (acc_sw) begin
        state <= SWITCH;
        sel   <= acc_src;
      end else if (state == SWITCH && zero) begin
        done    <= 1'b1;
        cur_src <= sel;
        state   <= DWELL_CYCLES == 0 ? IDLE : DWELL;
      end else if (state == DWELL && zero)
        state <= IDLE;
    end
endmodule

// File: tb/tb_dfs_sel_ctrl.sv
// tb_dfs_sel_ctrl: directed scenarios plus random traffic against a cycle-number reference model
module tb_dfs_sel_ctrl;
  localparam int S = 4;
  localparam int D = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_valid = 2'b11, req_src = 2'b00, req_ready;
  logic sel, cur_src, busy, done;
  int errors = 0, checks = 0;
  int cyc = 0, sw_last = -1, dw_last = -1, done_at = -1;
  logic m_sel = 1'b0, m_cur = 1'b0;
  logic [1:0] got_rdy;
  logic got_sel, got_cur, got_busy, got_done;
  always #5 clk = ~clk;
  dfs_sel_ctrl #(.SETTLE_CYCLES(S), .DWELL_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_src   (req_src),
    .req_ready (req_ready),
    .sel       (sel),
    .cur_src   (cur_src),
    .busy      (busy),
    .done      (done)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // The model tracks the cycle numbers at which the active switch and dwell end.
  task automatic cycle();
    logic b, dw, idle, dn, src;
    logic [1:0] r;
    @(negedge clk);
    if (cyc == done_at) m_cur = m_sel;
    b    = cyc <= sw_last;
    dw   = !b && cyc <= dw_last;
    idle = !b && !dw;
    dn   = cyc == done_at;
    r[0] = !rst && req_valid[0] && !b;
    r[1] = !rst && req_valid[1] && !r[0] && (idle || (dw && req_src[1] == m_sel));
    got_rdy = req_ready; got_sel = sel; got_cur = cur_src; got_busy = busy; got_done = done;
    check("ready", {6'd0, req_ready}, {6'd0, r});
    check("sel", {7'd0, sel}, {7'd0, m_sel});
    check("cur_src", {7'd0, cur_src}, {7'd0, m_cur});
    check("busy", {7'd0, busy}, {7'd0, b});
    check("done", {7'd0, done}, {7'd0, dn});
    src = r[0] ? req_src[0] : req_src[1];
    if (rst) begin
      m_sel = 1'b0; m_cur = 1'b0; sw_last = -1; dw_last = -1; done_at = -1;
    end else if (|r && src != m_sel) begin
      m_sel = src; sw_last = cyc + S; done_at = cyc + S + 1; dw_last = cyc + S + D;
    end
    cyc++;
    @(posedge clk); #1;
    req_valid = req_valid & ~r;
  endtask
  initial begin
    int k;
    @(posedge clk); #1;
    cycle(); cycle();
    check("rst_ready", {6'd0, got_rdy}, 8'd0);
    check("rst_sel", {7'd0, got_sel}, 8'd0);
    rst = 1'b0; req_valid = 2'b11; req_src = 2'b01;
    cycle();
    check("arb_ready", {6'd0, got_rdy}, 8'h01);
    for (k = 1; k < 20; k++) begin
      cycle();
      if (got_rdy[1]) break;
    end
    check("arb_wait", 8'(k), 8'd13);
    cycle();
    check("arb_sel", {7'd0, got_sel}, 8'd0);
    repeat (12) cycle();
    req_valid = 2'b10; req_src = 2'b10;
    cycle();
    check("basic_ready", {6'd0, got_rdy}, 8'h02);
    cycle();
    check("basic_sel", {7'd0, got_sel}, 8'd1);
    check("basic_busy", {7'd0, got_busy}, 8'd1);
    repeat (3) cycle();
    cycle();
    check("basic_done", {7'd0, got_done}, 8'd1);
    check("basic_cur", {7'd0, got_cur}, 8'd1);
    cycle();
    req_valid = 2'b01; req_src = 2'b00;
    cycle();
    check("pre_ready", {6'd0, got_rdy}, 8'h01);
    cycle();
    check("pre_sel", {7'd0, got_sel}, 8'd0);
    repeat (3) cycle();
    cycle();
    check("pre_done", {7'd0, got_done}, 8'd1);
    repeat (8) cycle();
    req_valid = 2'b10; req_src = 2'b00;
    cycle();
    check("noop_ready", {6'd0, got_rdy}, 8'h02);
    cycle();
    check("noop_busy", {7'd0, got_busy}, 8'd0);
    check("noop_done", {7'd0, got_done}, 8'd0);
    req_valid = 2'b10; req_src = 2'b10;
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; req_valid = 2'b10; req_src = 2'b10;
    cycle();
    check("mrst_sel", {7'd0, got_sel}, 8'd0);
    check("mrst_busy", {7'd0, got_busy}, 8'd0);
    check("mrst_ready", {6'd0, got_rdy}, 8'h02);
    repeat (3000) begin
      rst = $urandom_range(99) == 0;
      for (int i = 0; i < 2; i++)
        if (!req_valid[i] && $urandom_range(2) == 0) begin
          req_valid[i] = 1'b1;
          req_src[i]   = 1'($urandom);
        end
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
